// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command-bus checkers: command encodings,
// error codes, init-checker states and mode-register field positions.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_EARLY   = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_PRE_A10 = 3'd3;
  localparam logic [2:0] ERR_TIMING  = 3'd4;
  localparam logic [2:0] ERR_MODE    = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] ERR_ILLEGAL = 3'd7;

  // ST_MRS_CHK is evaluated on the same edge as the MRS and is never held.
  typedef enum logic [3:0] {
    ST_WAIT_PWR  = 4'd0,
    ST_WAIT_PRE  = 4'd1,
    ST_TRP       = 4'd2,
    ST_WAIT_AREF = 4'd3,
    ST_TRFC      = 4'd4,
    ST_MRS_CHK   = 4'd5,
    ST_TMRD      = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } state_e;

  localparam int A10_IDX = 10;
  localparam int CL_MSB  = 6;
  localparam int CL_LSB  = 4;
  localparam int BL_MSB  = 2;
  localparam int BL_LSB  = 0;

  function automatic logic mode_legal(input logic [2:0] cl, input logic [2:0] bl,
                                      input logic [1:0] ba);
    return (ba == 2'b00) && (cl == 3'd2 || cl == 3'd3) &&
           (bl <= 3'd3 || bl == 3'd7);
  endfunction

endpackage

// File: rtl/sdram_cmd_dec.sv
// Combinational SDRAM command decoder: {cs_n,ras_n,cas_n,we_n} to one-hot
// {nop, pre, aref, mrs, illegal}. Deselect (cs_n=1) decodes as nop.
module sdram_cmd_dec
  import sdram_pkg::*;
(
  input  logic [3:0] cmd,
  output logic       nop,
  output logic       pre,
  output logic       aref,
  output logic       mrs,
  output logic       illegal
);

  always_comb begin
    nop     = 1'b0;
    pre     = 1'b0;
    aref    = 1'b0;
    mrs     = 1'b0;
    illegal = 1'b0;
    if (cmd[3]) begin
      nop = 1'b1;
    end else begin
      case (cmd)
        CMD_NOP:  nop     = 1'b1;
        CMD_PRE:  pre     = 1'b1;
        CMD_AREF: aref    = 1'b1;
        CMD_MRS:  mrs     = 1'b1;
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sdram_init_chk.sv
// SDRAM power-up init sequence checker (PRE-ALL, N x AREF, MRS with spacing).
// Optional watchdog enabled by defining SDRAM_INIT_CHK_TIMEOUT_EN.
module sdram_init_chk
  import sdram_pkg::*;
#(
  parameter int PWR_CYCLES = 10000,
  parameter int T_RP       = 1,
  parameter int T_RFC      = 4,
  parameter int T_MRD      = 2,
  parameter int N_AREF     = 2
`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 65535
`endif
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic [3:0]  cmd,
  input  logic [11:0] sdram_addr,
  input  logic [1:0]  bank_addr,
  output logic        init_ok,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [11:0] mode_reg,
  output logic [2:0]  cas_lat,
  output logic [2:0]  burst_len,
  output logic [3:0]  aref_cnt,
  output state_e      dbg_state
);

  localparam logic [15:0] PWR_LAST = 16'(PWR_CYCLES - 1);
  localparam logic [7:0]  T_RP_L   = 8'(T_RP);
  localparam logic [7:0]  T_RFC_L  = 8'(T_RFC);
  localparam logic [7:0]  T_MRD_L  = 8'(T_MRD);
  localparam logic [3:0]  N_AREF_L = 4'(N_AREF);

  logic c_nop, c_pre, c_aref, c_mrs, c_illegal;

  sdram_cmd_dec u_dec (
    .cmd     (cmd),
    .nop     (c_nop),
    .pre     (c_pre),
    .aref    (c_aref),
    .mrs     (c_mrs),
    .illegal (c_illegal)
  );

  state_e      state_q, state_d;
  logic [15:0] pwr_cnt_q, pwr_cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  aref_cnt_q, aref_cnt_d;
  logic [11:0] mode_reg_q, mode_reg_d;
  logic        init_ok_q, init_ok_d;
  logic        init_err_q, init_err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        err_v;
  logic [2:0]  err_c;
  logic        aref_phase;
`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    gap_d      = gap_q;
    aref_cnt_d = aref_cnt_q;
    mode_reg_d = mode_reg_q;
    init_ok_d  = init_ok_q;
    init_err_d = init_err_q;
    err_code_d = err_code_q;
    err_v      = 1'b0;
    err_c      = ERR_NONE;
    aref_phase = 1'b0;
`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
    wd_d       = wd_q;
`endif

    if (state_q != ST_DONE && state_q != ST_ERR) begin
      if (c_illegal) begin
        err_v = 1'b1;
        err_c = ERR_ILLEGAL;
      end else begin
        case (state_q)
          ST_WAIT_PWR: begin
            if (!c_nop) begin
              err_v = 1'b1;
              err_c = ERR_EARLY;
            end else if (pwr_cnt_q == PWR_LAST) begin
              state_d = ST_WAIT_PRE;
            end else begin
              pwr_cnt_d = pwr_cnt_q + 16'd1;
            end
          end
          ST_WAIT_PRE: begin
            if (c_pre && sdram_addr[A10_IDX]) begin
              gap_d   = T_RP_L;
              state_d = ST_TRP;
            end else if (c_pre) begin
              err_v = 1'b1;
              err_c = ERR_PRE_A10;
            end else if (c_aref || c_mrs) begin
              err_v = 1'b1;
              err_c = ERR_ORDER;
            end
          end
          // A gap of 1 means the spacing is met: this edge behaves as WAIT_AREF.
          ST_TRP, ST_TRFC: begin
            if (gap_q > 8'd1) begin
              if (!c_nop) begin
                err_v = 1'b1;
                err_c = ERR_TIMING;
              end else begin
                gap_d = gap_q - 8'd1;
              end
            end else begin
              aref_phase = 1'b1;
            end
          end
          ST_WAIT_AREF: aref_phase = 1'b1;
          ST_TMRD: begin
            if (!c_nop) begin
              err_v = 1'b1;
              err_c = ERR_TIMING;
            end else if (gap_q <= 8'd1) begin
              state_d   = ST_DONE;
              init_ok_d = 1'b1;
            end else begin
              gap_d = gap_q - 8'd1;
            end
          end
          default: ;
        endcase

        if (aref_phase) begin
          if (c_aref) begin
            aref_cnt_d = (aref_cnt_q == 4'hF) ? aref_cnt_q : aref_cnt_q + 4'd1;
            gap_d      = T_RFC_L;
            state_d    = ST_TRFC;
          end else if (c_mrs) begin
            if (aref_cnt_q < N_AREF_L) begin
              err_v = 1'b1;
              err_c = ERR_ORDER;
            end else if (mode_legal(sdram_addr[CL_MSB:CL_LSB],
                                    sdram_addr[BL_MSB:BL_LSB], bank_addr)) begin
              mode_reg_d = sdram_addr;
              gap_d      = T_MRD_L;
              state_d    = ST_TMRD;
            end else begin
              err_v = 1'b1;
              err_c = ERR_MODE;
            end
          end else if (c_pre) begin
            err_v = 1'b1;
            err_c = ERR_ORDER;
          end else begin
            state_d = ST_WAIT_AREF;
          end
        end
      end
    end

`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
    // Watchdog runs from WAIT_PRE entry and freezes once DONE or ERR is reached.
    if (state_q inside {ST_WAIT_PRE, ST_TRP, ST_WAIT_AREF, ST_TRFC, ST_TMRD}) begin
      wd_d = wd_q + 16'd1;
      if (!err_v && state_d != ST_DONE && {1'b0, wd_q} >= 17'(TIMEOUT - 1)) begin
        err_v = 1'b1;
        err_c = ERR_TIMEOUT;
      end
    end
`endif

    if (err_v) begin
      state_d    = ST_ERR;
      init_err_d = 1'b1;
      err_code_d = err_c;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q    <= ST_WAIT_PWR;
      pwr_cnt_q  <= '0;
      gap_q      <= '0;
      aref_cnt_q <= '0;
      mode_reg_q <= '0;
      init_ok_q  <= 1'b0;
      init_err_q <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      gap_q      <= gap_d;
      aref_cnt_q <= aref_cnt_d;
      mode_reg_q <= mode_reg_d;
      init_ok_q  <= init_ok_d;
      init_err_q <= init_err_d;
      err_code_q <= err_code_d;
`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign init_ok   = init_ok_q;
  assign init_err  = init_err_q;
  assign err_code  = err_code_q;
  assign mode_reg  = mode_reg_q;
  assign cas_lat   = mode_reg_q[CL_MSB:CL_LSB];
  assign burst_len = mode_reg_q[BL_MSB:BL_LSB];
  assign aref_cnt  = aref_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_init_chk.sv
// Directed bench for sdram_init_chk: drivers push expected completion records
// (init_ok/init_err rise) into a queue; a negedge monitor pops and compares.
module tb_sdram_init_chk;
  import sdram_pkg::*;

  localparam int W = 43;  // {idx[15:0], ok, err, code[2:0], mode[11:0], aref[3:0], cas[2:0], bl[2:0]}
  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_MRS  = 4'b0000;
  localparam logic [3:0] C_ACT  = 4'b0011;

  logic        s_clk = 1'b0;
  logic        s_rst = 1'b1;
  logic [3:0]  cmd = 4'b0111;
  logic [11:0] sdram_addr = '0;
  logic [1:0]  bank_addr = '0;
  logic        init_ok, init_err;
  logic [2:0]  err_code, cas_lat, burst_len;
  logic [11:0] mode_reg;
  logic [3:0]  aref_cnt;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int nidx     = 0;
  int next_idx = 0;
  logic prev_evt = 1'b0;
  logic [W-1:0] exp_q[$];

`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
  sdram_init_chk #(.TIMEOUT(100)) dut (
`else
  sdram_init_chk dut (
`endif
    .s_clk(s_clk), .s_rst(s_rst), .cmd(cmd), .sdram_addr(sdram_addr),
    .bank_addr(bank_addr), .init_ok(init_ok), .init_err(init_err),
    .err_code(err_code), .mode_reg(mode_reg), .cas_lat(cas_lat),
    .burst_len(burst_len), .aref_cnt(aref_cnt), .dbg_state(dbg_state)
  );

  // Clock and sample-index tracking (index 0 = first edge with s_rst low).
  always #10 s_clk = ~s_clk;
  always @(posedge s_clk) begin
    if (s_rst) next_idx <= 0;
    else       next_idx <= next_idx + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int idx, input logic ok, input logic err,
                            input logic [2:0] code, input logic [11:0] mode,
                            input logic [3:0] aref, input logic [2:0] cas,
                            input logic [2:0] bl);
    exp_q.push_back({16'(idx), ok, err, code, mode, aref, cas, bl});
  endtask

  // Monitor: compares each completion event against the queue head.
  always @(negedge s_clk) begin
    logic [W-1:0] e;
    if ((init_ok || init_err) && !prev_evt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'(init_ok | init_err), 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_index", next_idx - 1, int'(e[42:27]));
        chk("init_ok",     int'(init_ok),  int'(e[26]));
        chk("init_err",    int'(init_err), int'(e[25]));
        chk("err_code",    int'(err_code), int'(e[24:22]));
        chk("mode_reg",    int'(mode_reg), int'(e[21:10]));
        chk("aref_cnt",    int'(aref_cnt), int'(e[9:6]));
        chk("cas_lat",     int'(cas_lat),  int'(e[5:3]));
        chk("burst_len",   int'(burst_len), int'(e[2:0]));
      end
    end
    prev_evt <= init_ok | init_err;
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic step(input logic [3:0] c, input logic [11:0] a, input logic [1:0] b);
    cmd = c;
    sdram_addr = a;
    bank_addr = b;
    @(posedge s_clk);
    nidx++;
    @(negedge s_clk);
    cmd = C_NOP;
    sdram_addr = '0;
    bank_addr = '0;
  endtask

  task automatic cmd_at(input int i, input logic [3:0] c, input logic [11:0] a,
                        input logic [1:0] b);
    while (nidx < i) step(C_NOP, 12'h000, 2'b00);
    step(c, a, b);
  endtask

  task automatic chk_outs(input string tag, input logic ok, input logic err,
                          input logic [2:0] code, input logic [11:0] mode,
                          input logic [3:0] aref);
    chk({tag, "_init_ok"},  int'(init_ok),  int'(ok));
    chk({tag, "_init_err"}, int'(init_err), int'(err));
    chk({tag, "_err_code"}, int'(err_code), int'(code));
    chk({tag, "_mode_reg"}, int'(mode_reg), int'(mode));
    chk({tag, "_aref_cnt"}, int'(aref_cnt), int'(aref));
  endtask

  task automatic do_reset(input int cycles);
    s_rst = 1'b1;
    cmd = C_NOP;
    repeat (cycles) @(posedge s_clk);
    @(negedge s_clk);
    chk_outs("reset", 1'b0, 1'b0, 3'd0, 12'h000, 4'd0);
    chk("reset_cas_lat", int'(cas_lat), 0);
    chk("reset_burst_len", int'(burst_len), 0);
    s_rst = 1'b0;
    nidx = 0;
  endtask

  task automatic drain();
    int k = 0;
    #1;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge s_clk);
      #1;
      k++;
    end
    chk("event_timeout_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic legal_seq();
    expect_evt(10012, 1'b1, 1'b0, 3'd0, 12'h032, 4'd2, 3'd3, 3'd2);
    cmd_at(10001, C_PRE,  12'h400, 2'b00);
    cmd_at(10002, C_AREF, 12'h000, 2'b00);
    cmd_at(10006, C_AREF, 12'h000, 2'b00);
    cmd_at(10010, C_MRS,  12'h032, 2'b00);
    drain();
  endtask

  initial begin
    @(negedge s_clk);
    // 1: legal sequence, then DONE holds against further traffic
    do_reset(2);
    legal_seq();
    step(C_AREF, 12'h000, 2'b00);
    step(C_MRS, 12'h012, 2'b00);
    step(C_ACT, 12'h000, 2'b00);
    chk_outs("done_hold", 1'b1, 1'b0, 3'd0, 12'h032, 4'd2);

    // 2: early command, then ERR is sticky
    do_reset(1);
    expect_evt(50, 1'b0, 1'b1, 3'd1, 12'h000, 4'd0, 3'd0, 3'd0);
    cmd_at(50, C_PRE, 12'h400, 2'b00);
    drain();
    step(C_PRE, 12'h400, 2'b00);
    step(C_AREF, 12'h000, 2'b00);
    chk_outs("err_hold", 1'b0, 1'b1, 3'd1, 12'h000, 4'd0);

    // 3: illegal encoding outranks EARLY
    do_reset(1);
    expect_evt(100, 1'b0, 1'b1, 3'd7, 12'h000, 4'd0, 3'd0, 3'd0);
    cmd_at(100, C_ACT, 12'h000, 2'b00);
    drain();

    // 4: precharge without A10
    do_reset(1);
    expect_evt(10001, 1'b0, 1'b1, 3'd3, 12'h000, 4'd0, 3'd0, 3'd0);
    cmd_at(10001, C_PRE, 12'h000, 2'b00);
    drain();

    // 5: refresh spacing 3 < T_RFC
    do_reset(1);
    expect_evt(10005, 1'b0, 1'b1, 3'd4, 12'h000, 4'd1, 3'd0, 3'd0);
    cmd_at(10001, C_PRE,  12'h400, 2'b00);
    cmd_at(10002, C_AREF, 12'h000, 2'b00);
    cmd_at(10005, C_AREF, 12'h000, 2'b00);
    drain();

    // 6: illegal mode (CL=1), mode_reg stays 0
    do_reset(1);
    expect_evt(10010, 1'b0, 1'b1, 3'd5, 12'h000, 4'd2, 3'd0, 3'd0);
    cmd_at(10001, C_PRE,  12'h400, 2'b00);
    cmd_at(10002, C_AREF, 12'h000, 2'b00);
    cmd_at(10006, C_AREF, 12'h000, 2'b00);
    cmd_at(10010, C_MRS,  12'h012, 2'b00);
    drain();

    // 7: MRS after only one AREF
    do_reset(1);
    expect_evt(10006, 1'b0, 1'b1, 3'd2, 12'h000, 4'd1, 3'd0, 3'd0);
    cmd_at(10001, C_PRE,  12'h400, 2'b00);
    cmd_at(10002, C_AREF, 12'h000, 2'b00);
    cmd_at(10006, C_MRS,  12'h032, 2'b00);
    drain();

    // 8: reset mid-sequence at index 10004, then replay the legal sequence
    do_reset(1);
    cmd_at(10001, C_PRE,  12'h400, 2'b00);
    cmd_at(10002, C_AREF, 12'h000, 2'b00);
    while (nidx < 10004) step(C_NOP, 12'h000, 2'b00);
    chk("pre_reset_aref_cnt", int'(aref_cnt), 1);
    do_reset(1);
    legal_seq();

`ifdef SDRAM_INIT_CHK_TIMEOUT_EN
    // 9: watchdog fires 100 cycles after WAIT_PRE entry (index 10000)
    do_reset(1);
    expect_evt(10099, 1'b0, 1'b1, 3'd6, 12'h000, 4'd0, 3'd0, 3'd0);
    cmd_at(10001, C_PRE, 12'h400, 2'b00);
    while (nidx < 10099) step(C_NOP, 12'h000, 2'b00);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
